// File: rtl/mrisc_alu.sv
// Multi-cycle MRISC ALU: single-cycle arithmetic/logic ops, serial one-bit-per-cycle shifter.
// Latency 1 cycle (shifts: 1+N); start is only taken in IDLE, ignored while busy or done.
module mrisc_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  alu_control_signal,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        carry,
    output logic        zero,
    output logic        sign,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  kind;
    logic [31:0] work;
    logic [4:0]  cnt;

    logic        is_shift;
    logic [4:0]  n;
    logic [31:0] imm_res;
    logic        imm_carry;
    logic [31:0] step;
    logic        step_out;

    // Immediate-path result for non-shift codes and zero-length shifts.
    always_comb begin
        is_shift  = 1'b0;
        n         = alu_control_signal[3] ? op_b[4:0] : shamt;
        imm_res   = op_b;
        imm_carry = 1'b0;
        case (alu_control_signal)
            4'b0000: {imm_carry, imm_res} = {1'b0, op_a} + {1'b0, op_b};
            4'b0001: {imm_carry, imm_res} = {1'b0, ~op_b} + 33'd1;
            4'b0010: imm_res = op_a & op_b;
            4'b0011: imm_res = op_a ^ op_b;
            4'b0100, 4'b0101, 4'b0110,
            4'b1100, 4'b1101, 4'b1110: begin
                is_shift = 1'b1;
                imm_res  = op_a;
            end
            default: imm_res = op_b;
        endcase
    end

    // kind: 00 left, 01 logical right, 10 arithmetic right (work[31] still holds op_a[31]).
    always_comb begin
        step     = {work[30:0], 1'b0};
        step_out = work[31];
        case (kind)
            2'b01: begin
                step     = {1'b0, work[31:1]};
                step_out = work[0];
            end
            2'b10: begin
                step     = {work[31], work[31:1]};
                step_out = work[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            kind   <= 2'b00;
            work   <= 32'd0;
            cnt    <= 5'd0;
            result <= 32'd0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            sign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_shift && (n != 5'd0)) begin
                            work  <= op_a;
                            cnt   <= n;
                            kind  <= alu_control_signal[1:0];
                            state <= SHIFT;
                        end else begin
                            result <= imm_res;
                            carry  <= imm_carry;
                            zero   <= (imm_res == 32'd0);
                            sign   <= imm_res[31];
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result <= step;
                        carry  <= step_out;
                        zero   <= (step == 32'd0);
                        sign   <= step[31];
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mrisc_alu.sv
// Randomized + directed bench for mrisc_alu against an operator-level reference model.
module tb_mrisc_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control_signal;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        sign;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    mrisc_alu dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .alu_control_signal (alu_control_signal),
        .op_a               (op_a),
        .op_b               (op_b),
        .shamt              (shamt),
        .result             (result),
        .carry              (carry),
        .zero               (zero),
        .sign               (sign),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: result, carry and cycles-to-done straight from the operation table.
    task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic c, output int lat);
        int  ni;
        logic [32:0] wide;
        ni  = code[3] ? int'(b[4:0]) : int'(sh);
        c   = 1'b0;
        lat = 1;
        case (code)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
            4'd1: begin r = 32'd0 - b; c = (b == 32'd0); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4, 4'd12: begin r = a << ni; if (ni > 0) c = a[32-ni]; end
            4'd5, 4'd13: begin r = a >> ni; if (ni > 0) c = a[ni-1]; end
            4'd6, 4'd14: begin r = $signed(a) >>> ni; if (ni > 0) c = a[ni-1]; end
            default: r = b;
        endcase
        if ((code == 4'd4 || code == 4'd5 || code == 4'd6 ||
             code == 4'd12 || code == 4'd13 || code == 4'd14) && ni > 0)
            lat = ni + 1;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit hold, input string tag);
        logic [31:0] er;
        logic        ec;
        int          el;
        int          lat;
        int          nb;
        model(code, a, b, sh, er, ec, el);
        alu_control_signal = code;
        op_a  = a;
        op_b  = b;
        shamt = sh;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold;
        alu_control_signal = 4'($urandom_range(15));
        op_a  = $urandom;
        op_b  = $urandom;
        shamt = 5'($urandom_range(31));
        lat = 1;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, el);
        chk({tag, " busy cycles"}, nb, el - 1);
        chk({tag, " result"}, result, er);
        chk({tag, " carry"}, {31'd0, carry}, {31'd0, ec});
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
        chk({tag, " sign"}, {31'd0, sign}, {31'd0, er[31]});
        // A request presented during the DONE cycle must be dropped.
        start = 1'b1;
        alu_control_signal = 4'd0;
        op_a = 32'h1111_1111;
        op_b = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " idle after done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result held"}, result, er);
        @(posedge clk); #1;
        chk({tag, " no second op"}, {31'd0, done | busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        alu_control_signal = 4'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        shamt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'd0, carry, zero, sign, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        run_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, "add wrap");
        run_op(4'b1110, 32'h8000_0000, 32'h0000_0004, 5'd0, 1'b0, "shrav 4");
        run_op(4'b0001, 32'h1234_5678, 32'h0000_0000, 5'd0, 1'b0, "comp zero");
        run_op(4'b0100, 32'h1234_5678, 32'h0000_0000, 5'd0, 1'b0, "shll n0");
        run_op(4'b0100, 32'h0000_0001, 32'h0000_0000, 5'd31, 1'b1, "shll 31 held");
        run_op(4'b0110, 32'h8000_0001, 32'h0000_0000, 5'd1, 1'b0, "shra 1");
        run_op(4'b1101, 32'hF000_000F, 32'hFFFF_FFE3, 5'd0, 1'b1, "shrlv 3");
        run_op(4'b0111, 32'h1234_5678, 32'h8000_0000, 5'd9, 1'b0, "pass");

        for (int i = 0; i < 40; i++) begin
            logic [3:0] code;
            code = 4'($urandom_range(15));
            run_op(code, $urandom, $urandom, 5'($urandom_range(31)), bit'($urandom_range(1)),
                   $sformatf("rand%0d op%0d", i, code));
        end

        // Abandon a shift by reset in its third SHIFT cycle.
        alu_control_signal = 4'b0100;
        op_a  = 32'h0000_0001;
        shamt = 5'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid-shift busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-shift rst result", result, 32'd0);
        chk("mid-shift rst outputs", {27'd0, carry, zero, sign, busy, done}, 32'd0);
        rst = 1'b0;
        alu_control_signal = 4'b0000;
        op_a  = 32'd5;
        op_b  = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("post-rst accept done", {31'd0, done}, 32'd1);
        chk("post-rst accept result", result, 32'd12);
        @(posedge clk); #1;

        // Reset outranks start at the same edge.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst over start", {27'd0, carry, zero, sign, busy, done}, 32'd0);
        chk("rst over start result", result, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst over start idle", {31'd0, done | busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
